// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cpu_ctrl_pkg : shared encodings and helpers for the CPU pipeline control
// Revision     : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] MEM_STALL = 2'd1;
    localparam logic [1:0] HALT      = 2'd2;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Load in EX writes a register that the instruction in ID reads; $0 never hazards
    function automatic logic load_use(
        input logic       memread,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rt
    );
        return memread && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : enable-driven up counter that sticks at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : 5-stage pipeline sequencer (load-use, flush, cache stall)
// Revision         : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             dmem_busy_i,
    output logic             pc_write_o,
    output logic             ifid_stall_o,
    output logic             ifid_hazard_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_stall_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] lu_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [TO_W-1:0] wd;
    logic [TO_W-1:0] wd_nxt;
    logic            lu;
    logic            stall_en;
    logic            lu_en;
    logic            flush_en;

    assign lu    = load_use(idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i);
    assign err_o = (state == HALT);

    always_comb begin
        pc_write_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        ifid_hazard_o = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_stall_o  = 1'b0;
        stall_en      = 1'b0;
        lu_en         = 1'b0;
        flush_en      = 1'b0;
        state_nxt     = state;
        wd_nxt        = wd;

        if (!rst_i) begin
            state_nxt = RUN;
        end else if (state == HALT) begin
            ifid_stall_o = 1'b1;
            pipe_stall_o = 1'b1;
        end else if (dmem_busy_i) begin
            ifid_stall_o = 1'b1;
            pipe_stall_o = 1'b1;
            stall_en     = 1'b1;
            if (state == RUN) begin
                wd_nxt    = TO_W'(1);
                state_nxt = (TIMEOUT <= 1) ? HALT : MEM_STALL;
            end else begin
                wd_nxt = wd + TO_W'(1);
                if (wd == WD_LAST) begin
                    state_nxt = HALT;
                end
            end
        end else begin
            // RUN and the MEM_STALL release cycle share the same decisions
            state_nxt = RUN;
            wd_nxt    = '0;
            if (lu) begin
                ifid_hazard_o = 1'b1;
                idex_bubble_o = 1'b1;
                lu_en         = 1'b1;
            end else if (branch_taken_i) begin
                ifid_flush_o = 1'b1;
                pc_write_o   = 1'b1;
                flush_en     = 1'b1;
            end else begin
                pc_write_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
            wd    <= '0;
        end else begin
            state <= state_nxt;
            wd    <= wd_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (stall_en),
        .count (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (lu_en),
        .count (lu_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (flush_en),
        .count (flush_cnt_o)
    );

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage CPU.
- Decides each cycle whether the PC and pipeline registers advance, hold, flush or take a bubble, covering load-use hazards, taken branches/jumps and data-cache miss stalls.
- Drives the stall, hazard and flush controls of the IF/ID register, the bubble control of ID/EX and a global freeze for the later stages.
- Keeps saturating performance counters and a cache-stall watchdog.

Parameters:
CNT_W, 32, width of each performance counter
TIMEOUT, 1024, maximum consecutive dmem_busy_i cycles before the watchdog error
TO_W, 11, width of the watchdog counter (must hold TIMEOUT)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
ifid_rs_i  in  5  rs field of the instruction in ID
ifid_rt_i  in  5  rt field of the instruction in ID
ifid_uses_rt_i  in  1  ID instruction reads rt
idex_memread_i  in  1  instruction in EX is a load
idex_rt_i  in  5  destination register of the load in EX
branch_taken_i  in  1  branch resolved taken in ID, or jump in ID
dmem_busy_i  in  1  data cache is servicing a miss (level)
pc_write_o  out  1  PC update enable
ifid_stall_o  out  1  IF/ID hold (cache stall)
ifid_hazard_o  out  1  IF/ID hold (load-use)
ifid_flush_o  out  1  IF/ID clear to NOP
idex_bubble_o  out  1  zero ID/EX control fields
pipe_stall_o  out  1  freeze ID/EX, EX/MEM, MEM/WB
err_o  out  1  sticky watchdog error
stall_cnt_o  out  CNT_W  cycles spent in MEM_STALL
lu_cnt_o  out  CNT_W  load-use bubbles inserted
flush_cnt_o  out  CNT_W  IF/ID flushes issued

Behaviour:
- Reset (rst_i low, asynchronous): state=RUN, all counters 0, err_o=0. While in reset: pc_write_o=0 and every other control output 0.
- lu = idex_memread_i & (idex_rt_i!=0) & ((idex_rt_i==ifid_rs_i) | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i)). Combinational.
- The state machine has three states: RUN, MEM_STALL and HALT.
- RUN, dmem_busy_i=1 (same-cycle, combinational):
  - outputs: pipe_stall_o=1, ifid_stall_o=1, pc_write_o=0, ifid_flush_o=0, ifid_hazard_o=0, idex_bubble_o=0;
  - next state=MEM_STALL; watchdog counter loads 1.
- RUN, dmem_busy_i=0, lu=1:
  - outputs: ifid_hazard_o=1, idex_bubble_o=1, pc_write_o=0, ifid_flush_o=0;
  - lu_cnt_o increments at the clock edge.
- RUN, dmem_busy_i=0, lu=0, branch_taken_i=1:
  - outputs: ifid_flush_o=1, pc_write_o=1;
  - flush_cnt_o increments.
- RUN, no event: pc_write_o=1, all other controls 0.
- Priority: cache stall > load-use > flush. A branch whose operand depends on a load is suppressed, not flushed. It is re-evaluated after the bubble.
- MEM_STALL:
  - While dmem_busy_i=1, outputs are the same as the stall case above. stall_cnt_o increments every cycle, including the entry cycle, which is counted while in RUN.
  - The watchdog counter increments each cycle.
  - When dmem_busy_i=0: next state=RUN. In that same cycle the RUN rules apply combinationally, so a branch held in ID flushes on the release cycle. There is no lost or duplicated flush.
  - Watchdog: when the counter reaches TIMEOUT while busy, next state=HALT.
- HALT:
  - err_o=1, pc_write_o=0, pipe_stall_o=1, ifid_stall_o=1.
  - Left only by reset.
- Counters saturate at all-ones; they do not wrap.
- Latency: all hold/flush/bubble controls take effect at the next rising edge in the pipeline registers. No extra cycle of latency is added.
- Reset asserted mid-stall: immediate return to RUN and counters cleared. The cache is expected to be reset by the same rst_i.

Decomposition:
- Shared package (cpu_ctrl_pkg): state encoding RUN=2'd0, MEM_STALL=2'd1, HALT=2'd2, and the NOP instruction constant.
- One natural sub-module, sat_counter (parameterised width, enable, asynchronous active-low clear), instantiated three times for the performance counters.

Test Plan:
- Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 for one cycle -> ifid_hazard_o=1, idex_bubble_o=1, pc_write_o=0 for exactly that cycle; lu_cnt_o=1. The same stimulus with idex_rt_i=0 gives no hazard.
- Taken branch: branch_taken_i=1 with no hazard -> ifid_flush_o=1, pc_write_o=1; flush_cnt_o=1.
- Cache miss: dmem_busy_i high for 7 cycles with branch_taken_i=1 throughout -> ifid_stall_o=pipe_stall_o=1 and ifid_flush_o=0 for 7 cycles; on the release cycle ifid_flush_o=1; stall_cnt_o=7; state returns to RUN.
- Priority: lu=1 and branch_taken_i=1 together -> hazard and bubble only, no flush. With dmem_busy_i=1 added, only stall is asserted.
- Watchdog: TIMEOUT=8, dmem_busy_i held high -> err_o rises after 8 busy cycles and stays high after busy drops, until rst_i is pulsed low asynchronously between edges; after that err_o=0 and the counters are 0.
- Saturation: CNT_W=3, 10 flushes -> flush_cnt_o=7.
